// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit ahead of MEM; word-aligned access, lane masks,
// load extension, alignment/funct3 error flagging, valid/ready req/resp.
// Ports: clk, rst (async active-low); req_* from EXU; resp_* to WBU;
//        mem_read/mem_write/mem_addr/mem_wdata/mem_mask/mem_rdata to MEM.
module lsu_ctrl #(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mask,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_wen;
    logic [1:0]  r_off;
    logic [2:0]  r_f3;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_mask;

    logic        w_f3_ok;
    logic        w_aligned;
    logic        w_legal;
    logic [3:0]  w_mask;
    logic [31:0] w_wdata;
    logic [4:0]  w_sh_req;
    logic [4:0]  w_sh_rsp;
    logic [31:0] w_shift;
    logic [31:0] w_ldata;

    assign w_sh_req = {req_addr[1:0], 3'b000};
    assign w_sh_rsp = {r_off, 3'b000};

    // Legality: funct3 must exist for the access kind, and halves/words
    // must be naturally aligned.
    always_comb begin
        w_f3_ok   = 1'b0;
        w_aligned = 1'b1;
        case (req_funct3)
            3'd0, 3'd1, 3'd2: w_f3_ok = 1'b1;
            3'd4, 3'd5:       w_f3_ok = !req_wen;
            default:          w_f3_ok = 1'b0;
        endcase
        case (req_funct3[1:0])
            2'd1:    w_aligned = !req_addr[0];
            2'd2:    w_aligned = (req_addr[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
    end

    assign w_legal = w_f3_ok && w_aligned;

    // Store lane placement; loads report a full mask and zero data.
    always_comb begin
        w_mask  = 4'b1111;
        w_wdata = '0;
        if (req_wen) begin
            w_wdata = req_wdata;
            case (req_funct3[1:0])
                2'd0: begin
                    w_mask  = 4'b0001 << req_addr[1:0];
                    w_wdata = {24'b0, req_wdata[7:0]} << w_sh_req;
                end
                2'd1: begin
                    w_mask  = 4'b0011 << req_addr[1:0];
                    w_wdata = {16'b0, req_wdata[15:0]} << w_sh_req;
                end
                default: ;
            endcase
        end
    end

    assign w_shift = mem_rdata >> w_sh_rsp;

    always_comb begin
        case (r_f3)
            3'd0:    w_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
            3'd1:    w_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
            3'd4:    w_ldata = {24'b0, w_shift[7:0]};
            3'd5:    w_ldata = {16'b0, w_shift[15:0]};
            default: w_ldata = w_shift;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_wen        <= 1'b0;
            r_off        <= '0;
            r_f3         <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_mask   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_wen       <= req_wen;
                        r_off       <= req_addr[1:0];
                        r_f3        <= req_funct3;
                        r_req_ready <= 1'b0;
                        if (w_legal) begin
                            r_state     <= S_ACCESS;
                            r_cnt       <= LAT_M1;
                            r_mem_addr  <= {req_addr[31:2], 2'b00};
                            r_mem_wdata <= w_wdata;
                            r_mem_mask  <= w_mask;
                            r_mem_read  <= !req_wen;
                            // Single write, placed in the final access cycle.
                            r_mem_write <= req_wen && (LAT_M1 == 4'd0);
                        end else begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state      <= S_RESP;
                        r_mem_read   <= 1'b0;
                        r_mem_write  <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_wen ? 32'd0 : w_ldata;
                    end else begin
                        r_cnt       <= r_cnt - 4'd1;
                        r_mem_write <= r_wen && (r_cnt == 4'd1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= '0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign mem_read   = r_mem_read;
    assign mem_write  = r_mem_write;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_mask   = r_mem_mask;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: three lsu_ctrl instances (LATENCY 1, 3, 4) over a shared
// byte-masked word memory; responses checked against a scoreboard queue.
module tb_lsu_ctrl;
    typedef struct {
        int          k;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];
    logic        mem_read   [3];
    logic        mem_write  [3];
    logic [31:0] mem_addr   [3];
    logic [31:0] mem_wdata  [3];
    logic [3:0]  mem_mask   [3];
    logic [31:0] mem_rdata  [3];

    logic [31:0] mem [256];
    int          rd_cnt [3];
    int          wr_cnt [3];
    exp_t        sb [$];
    int          total;
    int          bad;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        lsu_ctrl #(.LATENCY(LAT)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_wen    (req_wen),
            .req_addr   (req_addr),
            .req_wdata  (req_wdata),
            .req_funct3 (req_funct3),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g]),
            .mem_read   (mem_read[g]),
            .mem_write  (mem_write[g]),
            .mem_addr   (mem_addr[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_mask   (mem_mask[g]),
            .mem_rdata  (mem_rdata[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 3; k++) mem_rdata[k] = mem[mem_addr[k][9:2]];
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mem_write[k] === 1'b1) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_mask[k][b])
                        mem[mem_addr[k][9:2]][b*8 +: 8] <= mem_wdata[k][b*8 +: 8];
                end
            end
        end
    end

    // Response monitor: every handshake pops one expected entry.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (mem_read[k] === 1'b1) rd_cnt[k]++;
            if (mem_write[k] === 1'b1) wr_cnt[k]++;
            if (resp_valid[k] === 1'b1 && resp_ready[k] === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL resp_unexpected inst=%0d got rdata=%h err=%b want no response",
                             k, resp_rdata[k], resp_err[k]);
                end else begin
                    e = sb.pop_front();
                    if (e.k != k || resp_rdata[k] !== e.rd || resp_err[k] !== e.err) begin
                        bad++;
                        $display("FAIL resp inst=%0d got rdata=%h err=%b want inst=%0d rdata=%h err=%b",
                                 k, resp_rdata[k], resp_err[k], e.k, e.rd, e.err);
                    end
                end
            end
        end
    end

    task automatic send(input int k, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] exp_rd, input logic exp_err,
                        output int lat, output int rds, output int wrs,
                        output logic [31:0] a, output logic [31:0] wd,
                        output logic [3:0] m);
        int rd0;
        int wr0;
        @(negedge clk);
        req_wen    = wen;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        req_valid[k] = 1'b1;
        sb.push_back('{k: k, err: exp_err, rd: exp_rd});
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        rd0 = rd_cnt[k];
        wr0 = wr_cnt[k];
        @(negedge clk);
        a   = mem_addr[k];
        wd  = mem_wdata[k];
        m   = mem_mask[k];
        lat = 0;
        while (resp_valid[k] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (resp_valid[k] !== 1'b1) lat = -1;
        @(posedge clk);
        #1;
        rds = rd_cnt[k] - rd0;
        wrs = wr_cnt[k] - wr0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({resp_valid[k], resp_err[k], mem_read[k], mem_write[k], resp_rdata[k],
                 mem_addr[k], mem_wdata[k], mem_mask[k]} !== 104'd0) begin
                bad++;
                $display("FAIL reset_outputs inst=%0d got addr=%h wdata=%h mask=%b rd=%b wr=%b rv=%b want all zero",
                         k, mem_addr[k], mem_wdata[k], mem_mask[k], mem_read[k], mem_write[k], resp_valid[k]);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (req_ready[k] !== 1'b1) begin
                bad++;
                $display("FAIL reset_ready inst=%0d got %b want 1", k, req_ready[k]);
            end
        end
    endtask

    task automatic test_loads;
        int lat, rds, wrs;
        logic [31:0] a, wd;
        logic [3:0] m;
        logic [31:0] t_addr [5];
        logic [2:0]  t_f3   [5];
        logic [31:0] t_exp  [5];
        t_addr = '{32'h80000102, 32'h80000100, 32'h80000101, 32'h80000100, 32'h80000102};
        t_f3   = '{3'd5, 3'd1, 3'd4, 3'd2, 3'd1};
        t_exp  = '{32'h000080FF, 32'h00007F01, 32'h0000007F, 32'h80FF7F01, 32'hFFFF80FF};
        send(0, 1'b0, 32'h80000103, 32'h0, 3'd0, 32'hFFFFFF80, 1'b0, lat, rds, wrs, a, wd, m);
        total++;
        if (lat !== 1 || rds !== 1 || wrs !== 0 || a !== 32'h80000100 || m !== 4'b1111) begin
            bad++;
            $display("FAIL lb_access got lat=%0d rd=%0d wr=%0d addr=%h mask=%b want lat=1 rd=1 wr=0 addr=80000100 mask=1111",
                     lat, rds, wrs, a, m);
        end
        for (int i = 0; i < 5; i++) begin
            send(0, 1'b0, t_addr[i], 32'h0, t_f3[i], t_exp[i], 1'b0, lat, rds, wrs, a, wd, m);
            total++;
            if (lat !== 1 || rds !== 1 || wrs !== 0 || a !== 32'h80000100) begin
                bad++;
                $display("FAIL load_access idx=%0d got lat=%0d rd=%0d wr=%0d addr=%h want lat=1 rd=1 wr=0 addr=80000100",
                         i, lat, rds, wrs, a);
            end
        end
    endtask

    task automatic test_errors;
        int lat, rds, wrs;
        logic [31:0] a, wd;
        logic [3:0] m;
        logic        t_wen  [5];
        logic [31:0] t_addr [5];
        logic [2:0]  t_f3   [5];
        t_wen  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        t_addr = '{32'h80000002, 32'h80000100, 32'h80000101, 32'h80000100, 32'h80000102};
        t_f3   = '{3'd2, 3'd3, 3'd1, 3'd6, 3'd2};
        for (int i = 0; i < 5; i++) begin
            send(0, t_wen[i], t_addr[i], 32'h55AA55AA, t_f3[i], 32'h0, 1'b1, lat, rds, wrs, a, wd, m);
            total++;
            if (lat !== 0 || rds !== 0 || wrs !== 0) begin
                bad++;
                $display("FAIL err_access idx=%0d got lat=%0d rd=%0d wr=%0d want lat=0 rd=0 wr=0",
                         i, lat, rds, wrs);
            end
        end
    endtask

    task automatic test_backpressure;
        int  rd0;
        bit  ok;
        ok = 1'b1;
        @(negedge clk);
        resp_ready[1] = 1'b0;
        req_wen    = 1'b0;
        req_addr   = 32'h80000100;
        req_funct3 = 3'd2;
        req_valid[1] = 1'b1;
        sb.push_back('{k: 1, err: 1'b0, rd: 32'h80FF7F01});
        @(posedge clk);
        #1;
        rd0 = rd_cnt[1];
        req_addr = 32'h80000004;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_read[1] !== 1'b1 || req_ready[1] !== 1'b0 || resp_valid[1] !== 1'b0) ok = 1'b0;
            @(posedge clk);
        end
        total++;
        if (!ok || rd_cnt[1] - rd0 !== 3) begin
            bad++;
            $display("FAIL bp_access got ok=%b rd=%0d want ok=1 rd=3", ok, rd_cnt[1] - rd0);
        end
        ok = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (resp_valid[1] !== 1'b1 || resp_rdata[1] !== 32'h80FF7F01 ||
                resp_err[1] !== 1'b0 || req_ready[1] !== 1'b0 || mem_read[1] !== 1'b0)
                ok = 1'b0;
            @(posedge clk);
            #1;
            if (j == 3) resp_ready[1] = 1'b1;
        end
        req_valid[1] = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL bp_hold got stable=%b want 1", ok);
        end
        @(negedge clk);
        total++;
        if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1 || mem_read[1] !== 1'b0) begin
            bad++;
            $display("FAIL bp_after got rv=%b rr=%b rd=%b want rv=0 rr=1 rd=0",
                     resp_valid[1], req_ready[1], mem_read[1]);
        end
    endtask

    task automatic test_stores;
        int lat, rds, wrs;
        logic [31:0] a, wd;
        logic [3:0] m;
        logic [31:0] t_addr [3];
        logic [31:0] t_wd   [3];
        logic [2:0]  t_f3   [3];
        logic [31:0] e_addr [3];
        logic [31:0] e_wd   [3];
        logic [3:0]  e_m    [3];
        logic [31:0] e_word [3];
        t_addr = '{32'h80000006, 32'h80000101, 32'h80000008};
        t_wd   = '{32'h1234ABCD, 32'h0000AA55, 32'hCAFEF00D};
        t_f3   = '{3'd1, 3'd0, 3'd2};
        e_addr = '{32'h80000004, 32'h80000100, 32'h80000008};
        e_wd   = '{32'hABCD0000, 32'h00005500, 32'hCAFEF00D};
        e_m    = '{4'b1100, 4'b0010, 4'b1111};
        e_word = '{32'hABCD0000, 32'h80FF5501, 32'hCAFEF00D};
        for (int i = 0; i < 3; i++) begin
            send(0, 1'b1, t_addr[i], t_wd[i], t_f3[i], 32'h0, 1'b0, lat, rds, wrs, a, wd, m);
            total++;
            if (lat !== 1 || rds !== 0 || wrs !== 1 || a !== e_addr[i] || wd !== e_wd[i] || m !== e_m[i]) begin
                bad++;
                $display("FAIL store idx=%0d got lat=%0d rd=%0d wr=%0d addr=%h wdata=%h mask=%b want lat=1 rd=0 wr=1 addr=%h wdata=%h mask=%b",
                         i, lat, rds, wrs, a, wd, m, e_addr[i], e_wd[i], e_m[i]);
            end
        end
        for (int i = 0; i < 3; i++)
            send(0, 1'b0, e_addr[i], 32'h0, 3'd2, e_word[i], 1'b0, lat, rds, wrs, a, wd, m);
    endtask

    task automatic test_back_to_back;
        int lat, rds, wrs;
        logic [31:0] a, wd;
        logic [3:0] m;
        send(2, 1'b1, 32'h80000010, 32'h11223344, 3'd2, 32'h0, 1'b0, lat, rds, wrs, a, wd, m);
        total++;
        if (lat !== 4 || rds !== 0 || wrs !== 1 || m !== 4'b1111 || wd !== 32'h11223344) begin
            bad++;
            $display("FAIL b2b_sw got lat=%0d rd=%0d wr=%0d mask=%b wdata=%h want lat=4 rd=0 wr=1 mask=1111 wdata=11223344",
                     lat, rds, wrs, m, wd);
        end
        send(2, 1'b0, 32'h80000012, 32'h0, 3'd5, 32'h00001122, 1'b0, lat, rds, wrs, a, wd, m);
        total++;
        if (lat !== 4 || rds !== 4 || wrs !== 0) begin
            bad++;
            $display("FAIL b2b_lhu got lat=%0d rd=%0d wr=%0d want lat=4 rd=4 wr=0", lat, rds, wrs);
        end
        send(2, 1'b0, 32'h80000013, 32'h0, 3'd0, 32'h00000011, 1'b0, lat, rds, wrs, a, wd, m);
    endtask

    task automatic test_reset_midop;
        int lat, rds, wrs;
        int wr0;
        logic [31:0] a, wd;
        logic [3:0] m;
        bit quiet;
        wr0 = wr_cnt[2];
        @(negedge clk);
        req_wen    = 1'b1;
        req_addr   = 32'h8000000C;
        req_wdata  = 32'hDEADBEEF;
        req_funct3 = 3'd2;
        req_valid[2] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({resp_valid[2], resp_err[2], mem_read[2], mem_write[2], resp_rdata[2],
             mem_addr[2], mem_wdata[2], mem_mask[2]} !== 104'd0) begin
            bad++;
            $display("FAIL abort_outputs got addr=%h wdata=%h mask=%b wr=%b want all zero",
                     mem_addr[2], mem_wdata[2], mem_mask[2], mem_write[2]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready[2] !== 1'b1 || resp_valid[2] !== 1'b0) begin
            bad++;
            $display("FAIL abort_ready got rr=%b rv=%b want rr=1 rv=0", req_ready[2], resp_valid[2]);
        end
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid[2] !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (!quiet || wr_cnt[2] - wr0 !== 0) begin
            bad++;
            $display("FAIL abort_nowrite got quiet=%b writes=%0d want quiet=1 writes=0",
                     quiet, wr_cnt[2] - wr0);
        end
        send(0, 1'b0, 32'h8000000C, 32'h0, 3'd2, 32'h0, 1'b0, lat, rds, wrs, a, wd, m);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[64] = 32'h80FF7F01;
        for (int k = 0; k < 3; k++) begin
            rd_cnt[k]     = 0;
            wr_cnt[k]     = 0;
            req_valid[k]  = 1'b0;
            resp_ready[k] = 1'b1;
        end
        req_wen    = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_funct3 = 3'd0;
        rst        = 1'b0;
        test_reset();
        test_loads();
        test_errors();
        test_backpressure();
        test_stores();
        test_back_to_back();
        test_reset_midop();
        repeat (2) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got pending=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
